// File: rtl/tdc_result_reader_if.sv
// -----------------------------------------------------------------------------
// tdc_result_reader_if
// Groups the AS6500 SPI pins, the control inputs and the result outputs of
// tdc_result_reader into one bundle.
//   master : the reader itself (drives SPI outputs and the result bus)
//   slave  : the environment (TDC pins, enable, downstream consumer)
// Signals:
//   i_enable      frames may start when 1
//   i_tdc_intn    AS6500 INTERRUPT, active-low, asynchronous
//   i_spi_miso    SPI data from the TDC
//   o_spi_ssn     SPI chip select, active-low
//   o_spi_sclk    SPI clock, idle low
//   o_spi_mosi    SPI data to the TDC
//   o_tdc_new_sig one-cycle strobe: new rise/fall pair valid
//   o_rise_data   channel 1 stop field
//   o_fall_data   channel 2 stop field
//   o_ref_err     one-cycle pulse: reference index mismatch
//   o_busy        reader is not idle
// -----------------------------------------------------------------------------
interface tdc_result_reader_if;
  logic        i_enable;
  logic        i_tdc_intn;
  logic        i_spi_miso;
  logic        o_spi_ssn;
  logic        o_spi_sclk;
  logic        o_spi_mosi;
  logic        o_tdc_new_sig;
  logic [15:0] o_rise_data;
  logic [15:0] o_fall_data;
  logic        o_ref_err;
  logic        o_busy;

  modport master (
    input  i_enable, i_tdc_intn, i_spi_miso,
    output o_spi_ssn, o_spi_sclk, o_spi_mosi,
    output o_tdc_new_sig, o_rise_data, o_fall_data, o_ref_err, o_busy
  );

  modport slave (
    output i_enable, i_tdc_intn, i_spi_miso,
    input  o_spi_ssn, o_spi_sclk, o_spi_mosi,
    input  o_tdc_new_sig, o_rise_data, o_fall_data, o_ref_err, o_busy
  );
endinterface

// File: rtl/tdc_result_reader.sv
// -----------------------------------------------------------------------------
// tdc_result_reader
// SPI master (mode 1) that reads one result frame from an AS6500 whenever its
// interrupt is low, pairs channel 1 (rise) with channel 2 (fall), checks that
// both carry the same reference index and presents the 16-bit stop fields with
// a one-cycle strobe. A mismatching pair is dropped with a one-cycle error.
// Ports:
//   i_clk_50m  system clock
//   i_rst_n    asynchronous active-low reset
//   bus        tdc_result_reader_if.master (SPI pins, enable, results)
// Frame: opcode byte out, then 12 bytes in:
//   ch1 refindex, ch1 stop, ch2 refindex, ch2 stop (24 bits each, MSB first).
// -----------------------------------------------------------------------------
module tdc_result_reader #(
  parameter int         CLK_DIV   = 2,
  parameter int         SSN_SETUP = 2,
  parameter int         SSN_HOLD  = 2,
  parameter int         SSN_GAP   = 4,
  parameter logic [7:0] RD_OPCODE = 8'h68,
  parameter int         STOP_LSB  = 0
) (
  input logic               i_clk_50m,
  input logic               i_rst_n,
  tdc_result_reader_if.master bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_CHECK    = 3'd4;
  localparam logic [2:0] ST_CS_GAP   = 3'd5;

  localparam int              CNT_W      = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SSN_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SSN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SSN_GAP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [6:0]       LAST_BIT   = 7'd103;
  localparam logic [6:0]       FIRST_RX   = 7'd8;

  logic [2:0]       state;
  logic             intn_meta;
  logic             intn_sync;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] div_cnt;
  logic [6:0]       bit_cnt;
  logic             ssn;
  logic             sclk;
  logic             mosi;
  logic             new_sig;
  logic             ref_err;
  logic [15:0]      rise_data;
  logic [15:0]      fall_data;
  logic [95:0]      rx_sreg;
  logic             sclk_fall;

  // Bit driven on MOSI during frame bit idx: opcode MSB first, zeros after.
  function automatic logic tx_bit(input logic [6:0] idx);
    if (idx < 7'd8) return RD_OPCODE[~idx[2:0]];
    return 1'b0;
  endfunction

  // 16-bit window of a 24-bit stop value starting at STOP_LSB.
  function automatic logic [15:0] stop_field(input logic [23:0] stop);
    return 16'(stop >> STOP_LSB);
  endfunction

  // Interrupt synchronizer; idles high so reset never looks like a request.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      intn_meta <= 1'b1;
      intn_sync <= 1'b1;
    end else begin
      intn_meta <= bus.i_tdc_intn;
      intn_sync <= intn_meta;
    end
  end

  // End of an SCLK high phase: the TDC data bit is stable here.
  assign sclk_fall = (state == ST_SHIFT) && (div_cnt == DIV_LAST) && sclk;

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      ssn       <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      new_sig   <= 1'b0;
      ref_err   <= 1'b0;
      rise_data <= 16'h0;
      fall_data <= 16'h0;
    end else begin
      new_sig <= 1'b0;
      ref_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_enable && !intn_sync) begin
            state    <= ST_CS_SETUP;
            ssn      <= 1'b0;
            mosi     <= RD_OPCODE[7];
            wait_cnt <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (wait_cnt == SETUP_LAST) begin
            state   <= ST_SHIFT;
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            mosi    <= tx_bit(7'd0);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bit_cnt == LAST_BIT) begin
              // Low phase of the last period completed: frame fully clocked.
              state    <= ST_CS_HOLD;
              wait_cnt <= '0;
              mosi     <= 1'b0;
            end else begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + 7'd1;
              mosi    <= tx_bit(bit_cnt + 7'd1);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_CS_HOLD: begin
          if (wait_cnt == HOLD_LAST) begin
            state <= ST_CHECK;
            ssn   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (rx_sreg[95:72] == rx_sreg[47:24]) begin
            rise_data <= stop_field(rx_sreg[71:48]);
            fall_data <= stop_field(rx_sreg[23:0]);
            new_sig   <= 1'b1;
          end else begin
            ref_err <= 1'b1;
          end
          state    <= ST_CS_GAP;
          wait_cnt <= '0;
        end
        ST_CS_GAP: begin
          if (wait_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ssn   <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

  // Receive shift register; the opcode byte's MISO bits are not captured.
  always_ff @(posedge i_clk_50m) begin
    if (sclk_fall && (bit_cnt >= FIRST_RX)) begin
      rx_sreg <= {rx_sreg[94:0], bus.i_spi_miso};
    end
  end

  assign bus.o_spi_ssn     = ssn;
  assign bus.o_spi_sclk    = sclk;
  assign bus.o_spi_mosi    = mosi;
  assign bus.o_tdc_new_sig = new_sig;
  assign bus.o_ref_err     = ref_err;
  assign bus.o_rise_data   = rise_data;
  assign bus.o_fall_data   = fall_data;
  assign bus.o_busy        = (state != ST_IDLE);

endmodule

// File: doc/tdc_result_reader.md
Name: tdc_result_reader

Overview:
- SPI master that reads AS6500 result registers whenever the TDC raises its interrupt.
- Pairs channel 1 (rising edge) with channel 2 (falling edge) and checks that both carry the same reference index.
- Presents the 16-bit rise/fall stop values with a one-cycle new-data strobe to the downstream pulse/distance preprocessing stage.
- Sits between the AS6500 SPI pins and the measurement pipeline, in the i_clk_50m domain.

Parameters:
- CLK_DIV, 2: SCLK half-period in i_clk_50m cycles (min 1); the default gives 12.5 MHz.
- SSN_SETUP, 2: cycles from SSN falling to the first SCLK rising edge.
- SSN_HOLD, 2: cycles from the last SCLK falling edge to SSN rising.
- SSN_GAP, 4: minimum SSN-high cycles between frames.
- RD_OPCODE, 8'h68: read-results opcode (0x60 | start address 8).
- STOP_LSB, 0: bit offset of the 16-bit field taken from each 24-bit stop value (0..8).

Ports:
- i_clk_50m  in  1  system clock, 50 MHz
- i_rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  1 = frames may start; 0 = no new frame (a frame in progress completes)
- i_tdc_intn  in  1  AS6500 INTERRUPT, active-low, asynchronous
- i_spi_miso  in  1  SPI data from TDC
- o_spi_ssn  out  1  SPI chip select, active-low
- o_spi_sclk  out  1  SPI clock, idle low
- o_spi_mosi  out  1  SPI data to TDC
- o_tdc_new_sig  out  1  one-cycle strobe: new rise/fall pair valid
- o_rise_data  out  16  ch1 stop[STOP_LSB+15:STOP_LSB]
- o_fall_data  out  16  ch2 stop[STOP_LSB+15:STOP_LSB]
- o_ref_err  out  1  one-cycle pulse: ch1/ch2 reference index mismatch; frame discarded
- o_busy  out  1  1 while state != IDLE

Behaviour:
- Reset values: o_spi_ssn=1, o_spi_sclk=0, o_spi_mosi=0; o_tdc_new_sig, o_ref_err, o_busy=0; o_rise_data, o_fall_data=16'h0; state=IDLE; sync registers set to 1.
- i_tdc_intn passes through a 2-FF synchronizer; all decisions use the synchronized level.
- Frame: 13 bytes = 104 SCLK periods, MSB first.
  - Byte 0 is RD_OPCODE out; MISO is ignored.
  - Bytes 1-12 are received in this order: ch1 refindex[23:0], ch1 stop[23:0], ch2 refindex[23:0], ch2 stop[23:0], shifted into a 96-bit register.
  - MOSI=0 after the opcode.
- SPI mode 1 (CPOL=0, CPHA=1):
  - The master updates MOSI in the cycle SCLK rises.
  - The master samples MISO in the cycle SCLK falls.
  - SCLK toggles every CLK_DIV cycles.
- State machine:
  - IDLE: o_busy=0. If i_enable=1 and synced intn=0, go to CS_SETUP, drive SSN low and MOSI=opcode bit 7.
  - CS_SETUP: wait SSN_SETUP cycles, then go to SHIFT.
  - SHIFT: 104 full SCLK periods; a bit counter (0..103) and a CLK_DIV divider count. After the 104th falling edge go to CS_HOLD with SCLK=0.
  - CS_HOLD: wait SSN_HOLD cycles, drive SSN high, go to CHECK.
  - CHECK (1 cycle):
    - If ch1 refindex == ch2 refindex: register both 16-bit fields into o_rise_data/o_fall_data and pulse o_tdc_new_sig for exactly 1 cycle.
    - Otherwise: pulse o_ref_err for 1 cycle; data outputs keep their previous values.
    - Strobes appear the cycle after SSN rises. Go to CS_GAP.
  - CS_GAP: SSN high for SSN_GAP cycles, then IDLE.
- Defaults: SSN low = SSN_SETUP + 104*2*CLK_DIV + SSN_HOLD = 420 cycles; frame-to-frame minimum = 420 + 1 + SSN_GAP + 1 (IDLE) = 426 cycles.
- o_rise_data/o_fall_data are held stable until the next valid frame; the downstream stage samples them up to 2 cycles after the strobe.
- No sign or ordering check on rise vs fall; fall < rise is the consumer's concern.
- Interrupt still low after CS_GAP (FIFO not empty): a new frame starts from IDLE immediately; back-to-back reads are expected.
- i_enable falling mid-frame: the frame completes, including CHECK and strobe; no new frame starts.
- Interrupt rising mid-frame: ignored; the frame completes.
- Reset mid-frame: all outputs return to reset values immediately, SSN goes high asynchronously, and the partial frame is discarded.

Test Plan:
- Reset: assert i_rst_n=0 with intn=0 → ssn=1, sclk=0, mosi=0, rise/fall=0, no strobe; after release with enable=1, SSN falls within 4 cycles.
- Single frame, CLK_DIV=2: TDC model returns ch1 ref 0x000005, stop 0x001234; ch2 ref 0x000005, stop 0x001300 → MOSI carries 0x68 on the first 8 rising edges; exactly 104 SCLK rising edges; SSN low 420 cycles; 1 cycle after SSN rises new_sig=1 for 1 cycle with rise=0x1234, fall=0x1300, held afterwards.
- Ref mismatch: ch1 ref 0x000005, ch2 ref 0x000006 → o_ref_err 1-cycle pulse, no new_sig, rise/fall keep prior 0x1234/0x1300.
- Continuous interrupt (intn held low across 3 frames) → 3 frames, SSN high exactly SSN_GAP+2 cycles between them, 3 new_sig pulses.
- STOP_LSB=4, stop 0x012345 → rise=0x1234. Enable drop at bit 50: the frame completes with a strobe and no further SSN falls.
- Reset asserted at bit 60 → SSN=1 and SCLK=0 at once, no strobe; a fresh full frame follows release.
